// File: rtl/warp_scheduler.sv
// Per-core warp scheduler: walks each warp through fetch, issue and PC update
// and grants the single shared execute path to READY warps in round-robin order.
module warp_scheduler #(
  parameter int WARPS_PER_CORE = 4,
  parameter int PC_WIDTH       = 8,
  localparam int WIDX_W        = $clog2(WARPS_PER_CORE),
  localparam int NW_W          = WIDX_W + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [NW_W-1:0]     num_warps,
  output logic                done,
  output logic [WARPS_PER_CORE-1:0] fetch_req,
  input  logic [WARPS_PER_CORE-1:0] fetch_done,
  output logic [PC_WIDTH-1:0] pc [WARPS_PER_CORE],
  output logic                issue_valid,
  output logic [WIDX_W-1:0]   issue_warp,
  input  logic                issue_ready,
  input  logic                instr_is_halt,
  input  logic [PC_WIDTH-1:0] next_pc
);

  typedef enum logic [1:0] {
    CORE_IDLE,
    CORE_RUN,
    CORE_DONE
  } core_state_e;

  typedef enum logic [2:0] {
    W_OFF,
    W_FETCH,
    W_READY,
    W_EXEC,
    W_HALTED
  } warp_state_e;

  core_state_e   core_q, core_d;
  warp_state_e   warp_q [WARPS_PER_CORE];
  warp_state_e   warp_d [WARPS_PER_CORE];
  logic [PC_WIDTH-1:0] pc_q [WARPS_PER_CORE];
  logic [PC_WIDTH-1:0] pc_d [WARPS_PER_CORE];
  logic          issue_valid_q, issue_valid_d;
  logic [WIDX_W-1:0] issue_warp_q, issue_warp_d;
  logic [WIDX_W-1:0] rr_q, rr_d;

  logic [NW_W-1:0]   n_clamp;
  logic              all_halted;
  logic              grant_found;
  logic [WIDX_W-1:0] grant_idx;
  logic [WIDX_W-1:0] cand;

  always_comb begin
    core_d        = core_q;
    issue_valid_d = issue_valid_q;
    issue_warp_d  = issue_warp_q;
    rr_d          = rr_q;
    grant_found   = 1'b0;
    grant_idx     = '0;
    cand          = '0;
    all_halted    = 1'b1;
    for (int i = 0; i < WARPS_PER_CORE; i++) begin
      warp_d[i] = warp_q[i];
      pc_d[i]   = pc_q[i];
      if (warp_q[i] != W_HALTED) all_halted = 1'b0;
    end
    n_clamp = (num_warps > NW_W'(WARPS_PER_CORE)) ? NW_W'(WARPS_PER_CORE) : num_warps;

    case (core_q)
      CORE_IDLE, CORE_DONE: begin
        if (start) begin
          core_d = CORE_RUN;
          for (int i = 0; i < WARPS_PER_CORE; i++) begin
            warp_d[i] = (NW_W'(i) < n_clamp) ? W_FETCH : W_HALTED;
            pc_d[i]   = '0;
          end
        end
      end
      CORE_RUN: begin
        for (int i = 0; i < WARPS_PER_CORE; i++) begin
          if (warp_q[i] == W_FETCH && fetch_done[i]) warp_d[i] = W_READY;
        end
        if (issue_valid_q) begin
          if (issue_ready) begin
            issue_valid_d = 1'b0;
            if (instr_is_halt) begin
              warp_d[issue_warp_q] = W_HALTED;
            end else begin
              warp_d[issue_warp_q] = W_FETCH;
              pc_d[issue_warp_q]   = next_pc;
            end
          end
        end else begin
          // Search from the RR pointer; index arithmetic wraps at the power-of-2 width.
          for (int k = 0; k < WARPS_PER_CORE; k++) begin
            cand = rr_q + WIDX_W'(k);
            if (!grant_found && warp_q[cand] == W_READY) begin
              grant_found = 1'b1;
              grant_idx   = cand;
            end
          end
          if (grant_found) begin
            warp_d[grant_idx] = W_EXEC;
            issue_valid_d     = 1'b1;
            issue_warp_d      = grant_idx;
            rr_d              = grant_idx + 1'b1;
          end
        end
        if (all_halted) core_d = CORE_DONE;
      end
      default: core_d = CORE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_q        <= CORE_IDLE;
      issue_valid_q <= 1'b0;
      issue_warp_q  <= '0;
      rr_q          <= '0;
      for (int i = 0; i < WARPS_PER_CORE; i++) begin
        warp_q[i] <= W_OFF;
        pc_q[i]   <= '0;
      end
    end else begin
      core_q        <= core_d;
      issue_valid_q <= issue_valid_d;
      issue_warp_q  <= issue_warp_d;
      rr_q          <= rr_d;
      for (int i = 0; i < WARPS_PER_CORE; i++) begin
        warp_q[i] <= warp_d[i];
        pc_q[i]   <= pc_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < WARPS_PER_CORE; i++) begin
      fetch_req[i] = (warp_q[i] == W_FETCH);
      pc[i]        = pc_q[i];
    end
  end

  assign done        = (core_q == CORE_DONE);
  assign issue_valid = issue_valid_q;
  assign issue_warp  = issue_warp_q;

endmodule

// File: doc/warp_scheduler.md
Name: warp_scheduler

Overview:
Per-core warp scheduler. It sequences every warp through fetch, issue and PC update, and arbitrates the core's single shared execute path (ALU lanes, register files, LSU) among ready warps in round-robin order. It sits between the per-warp fetchers and the shared execute stage. It drives the per-warp fetch requests, the per-warp PCs and the current-warp select, and it reports block completion.

Parameters:
WARPS_PER_CORE, 4, number of warp contexts in the core (power of 2, ≥2)
PC_WIDTH, 8, instruction memory address width

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
start  in  1  launch the block; sampled only when the scheduler is in IDLE or DONE
num_warps  in  $clog2(WARPS_PER_CORE)+1  number of warps the block uses; values above WARPS_PER_CORE are clamped to WARPS_PER_CORE
done  out  1  block complete: all launched warps have halted
fetch_req  out  WARPS_PER_CORE  per-warp request to its fetcher; high while that warp is in FETCH
fetch_done  in  WARPS_PER_CORE  per-warp pulse: instruction for pc[i] has been latched by the fetcher
pc  out  WARPS_PER_CORE x PC_WIDTH  per-warp program counter (unpacked array)
issue_valid  out  1  current warp is presented to the execute stage
issue_warp  out  $clog2(WARPS_PER_CORE)  current warp index; drives current_warp in the core
issue_ready  in  1  execute stage has finished the issued instruction
instr_is_halt  in  1  issued instruction is HALT; valid while issue_valid
next_pc  in  PC_WIDTH  PC computed by the execute stage for the issued warp; valid while issue_valid

Behaviour:
- Core FSM states: IDLE, RUN, DONE.
- Per-warp FSM states: OFF, FETCH, READY, EXEC, HALTED.
- Reset (async, reset==0):
  - core goes to IDLE; all warps go to OFF; pc[*]=0.
  - done=0, fetch_req=0, issue_valid=0, issue_warp=0, round-robin pointer=0.
- Launch, IDLE/DONE + start==1:
  - core goes to RUN next edge; done clears.
  - warps 0..n-1 (n = clamped num_warps) go to FETCH with pc=0; the others go to HALTED.
  - n==0: core enters RUN, then DONE on the following edge.
- start is ignored while in RUN.
- FETCH → READY on the edge where fetch_done[i]==1. fetch_done for a warp not in FETCH is ignored.
- fetch_req[i] = (warp i in FETCH), combinational from the registered state.
- Arbitration:
  - Occurs on any edge in RUN where issue_valid==0 and at least one warp is READY.
  - Grant goes to the first READY warp at or after the RR pointer, searching with wrap-around.
  - Granted warp goes to EXEC; issue_warp is loaded with its index and issue_valid is set (registered, visible the next cycle).
  - RR pointer becomes granted index + 1, modulo WARPS_PER_CORE.
  - At most one warp is in EXEC at a time.
- Issue handshake (issue_valid & issue_ready), on that edge:
  - instr_is_halt==1: warp goes to HALTED; pc is unchanged.
  - otherwise: pc[w] <= next_pc and the warp returns to FETCH.
  - issue_valid clears.
  - No arbitration happens on the handshake edge, so back-to-back issue carries one idle cycle.
- While issue_valid==1 and issue_ready==0, issue_warp and pc[issue_warp] are held stable.
- Simultaneous events: fetch_done for other warps and the issue handshake on the same edge are all applied. A warp leaving FETCH that edge is eligible at the next arbitration.
- Completion: in RUN, when every warp is HALTED (evaluated on registered state, including a halt applied this edge), the core goes to DONE next edge.
- done is high only in DONE and holds until a new start.
- next_pc wraps naturally at PC_WIDTH; no overflow detection.
- Reset mid-operation aborts everything immediately. Outputs return to reset values asynchronously.

Test Plan:
- Reset/idle: assert reset=0 mid-RUN with issue_valid=1 → issue_valid, fetch_req, done drop to 0 and pc[*]=0 without a clock edge.
- Single warp: num_warps=1; fetch_done after 2 cycles; issue next_pc=1, then next_pc=2, then halt → pc[0] sequence 0,1,2; done=1 after the halt handshake; fetch_req[3:1] always 0.
- Round-robin fairness: num_warps=4, all fetch_done on the same cycle, issue_ready=1 always, never halt → issue_warp sequence 0,1,2,3,0 with one idle cycle between issues.
- Stall hold: issue_ready=0 for 5 cycles with warp 2 issued → issue_warp=2 and pc[2] stable. Meanwhile warps 0,1,3 reach READY but none are granted until the handshake.
- Clamp/zero: num_warps=7 (W=4) → warps 0–3 all fetch. num_warps=0 → done=1 two cycles after start, with no fetch_req.
- Restart: after done, start with num_warps=2 → done clears, pc[0]=pc[1]=0, fetch_req=4'b0011. start pulsed during RUN → no effect.
